string_search_seq: RTL

- Sequencer for the pattern/text match datapath: runs a naive substring search over one shared single-port synchronous-read memory that holds both text and pattern.
- Generates memory addresses and read enables, compares characters, and reports every match position plus a final match count.
- Sits between the top-level start/button logic and the character memory, replacing per-signal FSM strobes with a self-contained search engine.

---
 rtl/string_search_seq_pkg.sv | 21 ++
 rtl/string_search_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/string_search_seq_pkg.sv
// Shared definitions for the naive substring-search sequencer.
//
// Contents:
//   ST_W    - width of the state encoding (also the width of actual_state)
//   state_t - FSM state type with fixed, externally visible encodings
package string_search_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 4'd0,
        ST_INIT = 4'd1,
        ST_RD_T = 4'd2,
        ST_RD_P = 4'd3,
        ST_CMP  = 4'd4,
        ST_HIT  = 4'd5,
        ST_ADV  = 4'd6,
        ST_FIN  = 4'd7
    } state_t;

endpackage

// File: rtl/string_search_seq.sv
// Naive substring search engine over a single-port, synchronous-read memory
// that holds both the text and the pattern.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   start               - begin a search (only honoured in IDLE)
//   text_base, text_len - text location and length, latched at start
//   pat_base, pat_len   - pattern location and length, latched at start
//   mem_addr, mem_rd_en - memory read request; data returns next cycle
//   mem_rdata           - memory read data
//   busy                - high whenever the engine is not IDLE
//   done                - one-cycle pulse when the search finishes
//   match_valid         - one-cycle pulse per match found
//   match_pos           - text offset of the latest match (held)
//   match_count         - number of matches in the current/last search
//   actual_state        - raw state encoding for debug/LEDs
module string_search_seq
    import string_search_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] text_base,
    input  logic [ADDR_W-1:0] text_len,
    input  logic [ADDR_W-1:0] pat_base,
    input  logic [ADDR_W-1:0] pat_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              match_valid,
    output logic [ADDR_W-1:0] match_pos,
    output logic [ADDR_W:0]   match_count,
    output logic [ST_W-1:0]   actual_state
);

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_C = (ADDR_W + 1)'(1);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] text_base_q;
    logic [ADDR_W-1:0] text_len_q;
    logic [ADDR_W-1:0] pat_base_q;
    logic [ADDR_W-1:0] pat_len_q;
    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] j_q;
    logic [ADDR_W-1:0] pos_q;
    logic [DATA_W-1:0] t_char;
    logic [ADDR_W:0]   count_q;

    logic char_eq;
    logic last_char;
    logic last_align;
    logic no_search;

    // In CMP the pattern character is on mem_rdata; the text character was
    // captured one cycle earlier.
    assign char_eq    = (mem_rdata == t_char);
    assign last_char  = (j_q == (pat_len_q - ONE_A));
    // The last alignment to try is text_len-pat_len; INIT guarantees
    // pat_len <= text_len so this never underflows when reached.
    assign last_align = (i_q == (text_len_q - pat_len_q));
    assign no_search  = (pat_len_q == '0) || (pat_len_q > text_len_q);

    assign match_pos    = pos_q;
    assign match_count  = count_q;
    assign actual_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        match_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                state_nxt = no_search ? ST_FIN : ST_RD_T;
            end
            ST_RD_T: begin
                mem_addr  = text_base_q + i_q + j_q;
                mem_rd_en = 1'b1;
                state_nxt = ST_RD_P;
            end
            ST_RD_P: begin
                mem_addr  = pat_base_q + j_q;
                mem_rd_en = 1'b1;
                state_nxt = ST_CMP;
            end
            ST_CMP: begin
                if (!char_eq) begin
                    state_nxt = ST_ADV;
                end else if (last_char) begin
                    state_nxt = ST_HIT;
                end else begin
                    state_nxt = ST_RD_T;
                end
            end
            ST_HIT: begin
                match_valid = 1'b1;
                state_nxt   = ST_ADV;
            end
            ST_ADV: begin
                state_nxt = last_align ? ST_FIN : ST_RD_T;
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Index, latch and counter registers beside the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            text_base_q <= '0;
            text_len_q  <= '0;
            pat_base_q  <= '0;
            pat_len_q   <= '0;
            i_q         <= '0;
            j_q         <= '0;
            pos_q       <= '0;
            t_char      <= '0;
            count_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        text_base_q <= text_base;
                        text_len_q  <= text_len;
                        pat_base_q  <= pat_base;
                        pat_len_q   <= pat_len;
                        i_q         <= '0;
                        j_q         <= '0;
                        count_q     <= '0;
                    end
                end
                ST_INIT: begin
                    i_q     <= '0;
                    j_q     <= '0;
                    count_q <= '0;
                end
                ST_RD_P: begin
                    t_char <= mem_rdata;
                end
                ST_CMP: begin
                    if (char_eq) begin
                        // Load the position on the way into HIT so it is
                        // already valid while match_valid is high.
                        if (last_char) begin
                            pos_q <= i_q;
                        end else begin
                            j_q <= j_q + ONE_A;
                        end
                    end
                end
                ST_HIT: begin
                    count_q <= count_q + ONE_C;
                end
                ST_ADV: begin
                    if (!last_align) begin
                        i_q <= i_q + ONE_A;
                        j_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
